// File: rtl/ghostbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ghostbus_pkg
//  Description : Shared helpers for the ghostbus fan-out block: clog2,
//                select-field width and the parameter legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package ghostbus_pkg;

    localparam int MAX_NCH    = 8;
    localparam int MAX_RD_LAT = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of the stored channel index; never narrower than one bit.
    function automatic int sel_width(input int nch);
        return (clog2(nch) < 1) ? 1 : clog2(nch);
    endfunction

    // True when the parameter set describes a buildable fan-out.
    function automatic bit params_ok(input int aw, input int dw, input int nch,
                                     input int caw, input int rd_lat);
        return (nch >= 1) && (nch <= MAX_NCH) &&
               (rd_lat >= 1) && (rd_lat <= MAX_RD_LAT) &&
               (dw >= 1) && (caw >= 1) &&
               (aw >= caw + sel_width(nch));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghostbus_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ghostbus_tag_pipe
//  Description : Fixed-depth shift register carrying read tags alongside the
//                child read latency. One entry enters per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ghostbus_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int TW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag
);

    logic [DEPTH-1:0] r_valid;
    logic [TW-1:0]    r_tag [DEPTH];

    // Shift valid and tag one stage per cycle; reset discards in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ghostbus_fanout.sv
`default_nettype none
// ============================================================================
//  Module      : ghostbus_fanout
//  Description : Decodes an upstream ghostbus access into one of NCH child
//                windows, registers the request, tracks reads through a tag
//                pipe and muxes the returning child data back upstream.
//  Revision    : 1.0  initial release
// ============================================================================
module ghostbus_fanout
    import ghostbus_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int NCH    = 2,
    parameter int CAW    = 20,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     gb_addr,
    input  logic [DW-1:0]     gb_wdata,
    input  logic              gb_we,
    input  logic              gb_re,
    output logic [DW-1:0]     gb_rdata,
    output logic              gb_rvalid,
    output logic [CAW-1:0]    ch_addr,
    output logic [DW-1:0]     ch_wdata,
    output logic [NCH-1:0]    ch_we,
    output logic [NCH-1:0]    ch_re,
    input  logic [NCH*DW-1:0] ch_rdata,
    output logic [15:0]       miss_cnt
);

    localparam int SEL_W = sel_width(NCH);
    localparam int FW    = AW - CAW;     // width of the upstream select field
    localparam int TAG_W = SEL_W + 1;    // {sel, miss}; valid travels separately

    generate
        if (!params_ok(AW, DW, NCH, CAW, RD_LAT)) begin : g_param_check
            $fatal(1, "ghostbus_fanout: illegal parameter set");
        end
    endgenerate

    logic [FW-1:0]    w_sel_field;
    logic [SEL_W-1:0] w_sel;
    logic             w_hit;
    logic [NCH-1:0]   w_onehot;

    logic             r_rd_valid;
    logic [SEL_W-1:0] r_rd_sel;
    logic             r_rd_miss;

    logic             w_tag_valid;
    logic [TAG_W-1:0] w_tag;
    logic [SEL_W-1:0] w_out_sel;
    logic             w_out_miss;
    logic [DW-1:0]    w_mux_data;

    // The compare is one bit wider than the field so NCH always fits.
    assign w_sel_field = gb_addr[AW-1:CAW];
    assign w_hit       = ({1'b0, w_sel_field} < (FW+1)'(NCH));
    assign w_sel       = w_sel_field[SEL_W-1:0];
    assign w_onehot    = w_hit ? (NCH'(1) << w_sel) : '0;

    // Register the request once; strobes last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_addr    <= '0;
            ch_wdata   <= '0;
            ch_we      <= '0;
            ch_re      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_sel   <= '0;
            r_rd_miss  <= 1'b0;
        end else begin
            if (gb_we || gb_re) begin
                ch_addr <= gb_addr[CAW-1:0];
            end
            if (gb_we) begin
                ch_wdata <= gb_wdata;
            end
            ch_we      <= gb_we ? w_onehot : '0;
            ch_re      <= gb_re ? w_onehot : '0;
            r_rd_valid <= gb_re;
            r_rd_sel   <= w_sel;
            r_rd_miss  <= !w_hit;
        end
    end

    // Count each missed access once, even a combined write+read, and saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
        end else if ((gb_we || gb_re) && !w_hit && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // Tags enter from the registered request so they exit as child data lands.
    ghostbus_tag_pipe #(
        .DEPTH (RD_LAT),
        .TW    (TAG_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_rd_valid),
        .in_tag    ({r_rd_sel, r_rd_miss}),
        .out_valid (w_tag_valid),
        .out_tag   (w_tag)
    );

    assign w_out_sel  = w_tag[TAG_W-1:1];
    assign w_out_miss = w_tag[0];

    // Select the child slice named by the exiting tag.
    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_out_sel == SEL_W'(i)) begin
                w_mux_data = ch_rdata[i*DW +: DW];
            end
        end
    end

    // Capture the response; read data holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gb_rdata  <= '0;
            gb_rvalid <= 1'b0;
        end else begin
            gb_rvalid <= w_tag_valid;
            if (w_tag_valid) begin
                gb_rdata <= w_out_miss ? '0 : w_mux_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ghostbus_fanout.md
GHOSTBUS_FANOUT -- requirements
Module: ghostbus_fanout

Interface
REQ-001 Parameter AW, default 24, upstream byte/word address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter NCH, default 2, number of child channels, legal range 1..8.
REQ-004 Parameter CAW, default 20, per-child address window width; the block SHALL require AW >= CAW + max(1, clog2(NCH)) and SHALL fail elaboration otherwise.
REQ-005 Parameter RD_LAT, default 1, fixed child read latency in cycles, legal range 1..4.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 gb_addr  in  AW  upstream address.
REQ-009 gb_wdata  in  DW  upstream write data.
REQ-010 gb_we  in  1  upstream write strobe, one cycle per write.
REQ-011 gb_re  in  1  upstream read strobe, one cycle per read.
REQ-012 gb_rdata  out  DW  upstream read data.
REQ-013 gb_rvalid  out  1  one-cycle qualifier for gb_rdata.
REQ-014 ch_addr  out  CAW  shared child address, which is gb_addr[CAW-1:0].
REQ-015 ch_wdata  out  DW  shared child write data.
REQ-016 ch_we  out  NCH  per-child write strobe.
REQ-017 ch_re  out  NCH  per-child read strobe.
REQ-018 ch_rdata  in  NCH*DW  child read data; child i is in slice [i*DW +: DW].
REQ-019 miss_cnt  out  16  saturating count of out-of-window accesses.

Function
REQ-020 Channel select SHALL be sel = gb_addr[AW-1:CAW]; the access is a hit iff sel < NCH, and otherwise it is a miss.
REQ-021 The request path SHALL be registered once: ch_addr, ch_wdata, ch_we and ch_re SHALL update 1 cycle after the upstream strobe.
REQ-022 On a hit, only bit sel of ch_we/ch_re SHALL assert, for exactly one cycle.
REQ-023 On a miss, no ch_we/ch_re bit SHALL assert.
REQ-024 gb_we and gb_re asserted together SHALL both be forwarded to the same channel.
REQ-025 Each read SHALL push {valid, sel, miss} into a RD_LAT-deep tag shift register, one entry per cycle.
REQ-026 Reads are accepted back-to-back every cycle; there is no stall.
REQ-027 When a tag exits the shift register, gb_rdata SHALL register ch_rdata[sel] for a hit, or all-zero for a miss, and gb_rvalid SHALL pulse.
REQ-028 Total read latency SHALL be RD_LAT+2 cycles from gb_re to gb_rvalid.
REQ-029 Read responses SHALL return in request order.
REQ-030 miss_cnt SHALL increment once per missed read or write, including a simultaneous we+re miss.
REQ-031 miss_cnt SHALL hold at 16'hFFFF once it saturates.
REQ-032 gb_rdata SHALL hold its last value while gb_rvalid is low.
REQ-033 NCH=1 SHALL decode a single window: hit iff gb_addr[AW-1:CAW]==0.

Reset
REQ-034 On rst, the following SHALL clear asynchronously: ch_we, ch_re, ch_addr, ch_wdata, gb_rdata, gb_rvalid, all tag valids and miss_cnt.
REQ-035 Reads in flight when rst asserts SHALL be discarded: no gb_rvalid after reset release for any pre-reset read.
REQ-036 The first access SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-037 Parameter legality checks and the clog2 helper SHALL live in the shared package ghostbus_pkg.
REQ-038 The tag pipeline SHALL be one sub-module, ghostbus_tag_pipe, parametrised by depth and tag width.
REQ-039 Decode and the read mux SHALL be in the top module.
REQ-040 The child ports SHALL be flat vectors so the ghostbus generator can slice them per instance.

Verification
REQ-041 NCH=2, CAW=20: write 0x123456 to addr 0x100010 -> ch_we=2'b10, ch_addr=0x00010, ch_wdata=0x123456, 1 cycle later.
REQ-042 RD_LAT=2: reads to ch0 and ch1 on consecutive cycles, children return 0xA and 0xB -> gb_rvalid on cycles 4 and 5 with 0xA then 0xB.
REQ-043 NCH=3, read addr 0x300000 -> no ch_re, gb_rdata=0 with rvalid at RD_LAT+2, miss_cnt=1.
REQ-044 Preload miss_cnt to 0xFFFE, issue 3 misses -> miss_cnt=0xFFFF.
REQ-045 Issue a read, assert rst at cycle 1, release at cycle 3 -> gb_rvalid stays 0 through cycle 10.
REQ-046 Simultaneous we+re to ch0 -> ch_we[0] and ch_re[0] high in the same cycle, and the read returns normally.
